// File: rtl/riscv_core_pkg.sv
// Shared core types: datapath widths, the reservation-station entry record and
// the tag-compare helper used by wakeup and the optional RS_CDB_BYPASS_EN select path.
package riscv_core_pkg;

  localparam int XLEN   = 32;
  localparam int TAG_W  = 5;
  localparam int CTRL_W = 16;

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [TAG_W-1:0]  rd;
    logic              s1_valid;
    logic [TAG_W-1:0]  s1_tag;
    logic [XLEN-1:0]   s1_val;
    logic              s2_valid;
    logic [TAG_W-1:0]  s2_tag;
    logic [XLEN-1:0]   s2_val;
  } rs_entry_t;

  function automatic logic tag_match(input logic             bus_valid,
                                     input logic [TAG_W-1:0] bus_tag,
                                     input logic [TAG_W-1:0] src_tag);
    return bus_valid && (bus_tag == src_tag);
  endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: registers whatever the scheduler routes into it,
// applying result-bus wakeup on the way in. RS_CDB_BYPASS_EN adds same-cycle readiness.
module rs_entry
  import riscv_core_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  rs_entry_t        src_i,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output rs_entry_t        ent_o,
  output logic             ready_o,
  output logic [XLEN-1:0]  op1_o,
  output logic [XLEN-1:0]  op2_o
);

  rs_entry_t ent_d, ent_q;
  logic      s1_rdy, s2_rdy;

  // Wakeup acts on the routed source, so shifted and newly dispatched entries are covered too.
  always_comb begin
    ent_d = src_i;
    if (src_i.valid && !src_i.s1_valid && tag_match(cdb_valid, cdb_tag, src_i.s1_tag)) begin
      ent_d.s1_valid = 1'b1;
      ent_d.s1_val   = cdb_data;
    end
    if (src_i.valid && !src_i.s2_valid && tag_match(cdb_valid, cdb_tag, src_i.s2_tag)) begin
      ent_d.s2_valid = 1'b1;
      ent_d.s2_val   = cdb_data;
    end
    if (flush) ent_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ent_q <= '0;
    else        ent_q <= ent_d;
  end

`ifdef RS_CDB_BYPASS_EN
  assign s1_rdy = ent_q.s1_valid || tag_match(cdb_valid, cdb_tag, ent_q.s1_tag);
  assign s2_rdy = ent_q.s2_valid || tag_match(cdb_valid, cdb_tag, ent_q.s2_tag);
  assign op1_o  = ent_q.s1_valid ? ent_q.s1_val : cdb_data;
  assign op2_o  = ent_q.s2_valid ? ent_q.s2_val : cdb_data;
`else
  assign s1_rdy = ent_q.s1_valid;
  assign s2_rdy = ent_q.s2_valid;
  assign op1_o  = ent_q.s1_val;
  assign op2_o  = ent_q.s2_val;
`endif

  assign ready_o = ent_q.valid && s1_rdy && s2_rdy;
  assign ent_o   = ent_q;

endmodule

// File: rtl/rs_issue_scheduler.sv
// Age-ordered compacting reservation station feeding the integer ALU; oldest ready entry
// issues first. Define RS_CDB_BYPASS_EN for 0-cycle wakeup-to-issue.
module rs_issue_scheduler
  import riscv_core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [CTRL_W-1:0]          disp_ctrl,
  input  logic [TAG_W-1:0]           disp_rd,
  input  logic [XLEN-1:0]            disp_s1,
  input  logic [XLEN-1:0]            disp_s2,
  input  logic                       disp_s1_valid,
  input  logic                       disp_s2_valid,
  input  logic [TAG_W-1:0]           disp_rs1,
  input  logic [TAG_W-1:0]           disp_rs2,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [XLEN-1:0]            cdb_data,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [CTRL_W-1:0]          iss_ctrl,
  output logic [TAG_W-1:0]           iss_rd,
  output logic [XLEN-1:0]            iss_op1,
  output logic [XLEN-1:0]            iss_op2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH+1);

  rs_entry_t        ent     [DEPTH];
  rs_entry_t        ent_ext [DEPTH+1];
  rs_entry_t        src     [DEPTH];
  rs_entry_t        disp_entry;
  logic [DEPTH-1:0] rdy;
  logic [XLEN-1:0]  op1 [DEPTH];
  logic [XLEN-1:0]  op2 [DEPTH];

  logic [CNT_W-1:0] count_d, count_q;
  logic [CNT_W-1:0] sel_idx, wr_idx;
  logic             sel_found, disp_take, iss_take;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      rs_entry u_entry (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .src_i    (src[gi]),
        .cdb_valid(cdb_valid),
        .cdb_tag  (cdb_tag),
        .cdb_data (cdb_data),
        .ent_o    (ent[gi]),
        .ready_o  (rdy[gi]),
        .op1_o    (op1[gi]),
        .op2_o    (op2[gi])
      );
    end
  endgenerate

  // Lowest ready index is the oldest ready micro-op.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    iss_ctrl  = '0;
    iss_rd    = '0;
    iss_op1   = '0;
    iss_op2   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        sel_found = 1'b1;
        sel_idx   = CNT_W'(i);
        iss_ctrl  = ent[i].ctrl;
        iss_rd    = ent[i].rd;
        iss_op1   = op1[i];
        iss_op2   = op2[i];
      end
    end
  end

  assign iss_valid  = sel_found;
  assign disp_ready = (count_q < CNT_W'(DEPTH));
  assign count      = count_q;
  assign disp_take  = disp_valid && disp_ready && !flush;
  assign iss_take   = sel_found && iss_ready && !flush;
  assign wr_idx     = count_q - CNT_W'(iss_take);

  always_comb begin
    disp_entry          = '0;
    disp_entry.valid    = 1'b1;
    disp_entry.ctrl     = disp_ctrl;
    disp_entry.rd       = disp_rd;
    disp_entry.s1_valid = disp_s1_valid;
    disp_entry.s1_tag   = disp_rs1;
    disp_entry.s1_val   = disp_s1;
    disp_entry.s2_valid = disp_s2_valid;
    disp_entry.s2_tag   = disp_rs2;
    disp_entry.s2_val   = disp_s2;
  end

  // Entries at or above the issued slot take their younger neighbour; the top slot refills empty.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_ext[i] = ent[i];
    ent_ext[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      src[i] = ent_ext[i];
      if (iss_take && (CNT_W'(i) >= sel_idx)) src[i] = ent_ext[i+1];
      if (disp_take && (CNT_W'(i) == wr_idx)) src[i] = disp_entry;
    end
  end

  always_comb begin
    count_d = count_q + CNT_W'(disp_take) - CNT_W'(iss_take);
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed self-checking bench for rs_issue_scheduler (DEPTH=4); honours RS_CDB_BYPASS_EN.
module tb_rs_issue_scheduler;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [15:0] disp_ctrl;
  logic [4:0]  disp_rd;
  logic [31:0] disp_s1, disp_s2;
  logic        disp_s1_valid, disp_s2_valid;
  logic [4:0]  disp_rs1, disp_rs2;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        iss_valid;
  logic        iss_ready;
  logic [15:0] iss_ctrl;
  logic [4:0]  iss_rd;
  logic [31:0] iss_op1, iss_op2;
  logic [2:0]  count;

  int passed = 0;
  int total  = 0;

  rs_issue_scheduler #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_ctrl(disp_ctrl), .disp_rd(disp_rd),
    .disp_s1(disp_s1), .disp_s2(disp_s2), .disp_s1_valid(disp_s1_valid), .disp_s2_valid(disp_s2_valid),
    .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_ctrl(iss_ctrl), .iss_rd(iss_rd),
    .iss_op1(iss_op1), .iss_op2(iss_op2), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [15:0] c, input logic [4:0] rd,
                      input logic [31:0] a, input logic av, input logic [4:0] ra,
                      input logic [31:0] b, input logic bv, input logic [4:0] rb);
    disp_valid = 1'b1; disp_ctrl = c; disp_rd = rd;
    disp_s1 = a; disp_s1_valid = av; disp_rs1 = ra;
    disp_s2 = b; disp_s2_valid = bv; disp_rs2 = rb;
    $display("[tb] t=%0t disp ctrl=%h rd=%0d s1=%h/%0b/%0d s2=%h/%0b/%0d", $time, c, rd, a, av, ra, b, bv, rb);
  endtask

  task automatic idle();
    disp_valid = 1'b0; flush = 1'b0; cdb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iss_ready = 1'b0; idle();
    disp_ctrl = '0; disp_rd = '0; disp_s1 = '0; disp_s2 = '0;
    disp_s1_valid = 1'b0; disp_s2_valid = 1'b0; disp_rs1 = '0; disp_rs2 = '0;
    cdb_tag = '0; cdb_data = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
    total++; if (iss_valid !== 1'b0) $display("FAIL reset_iss_valid: got %b want 0", iss_valid); else passed++;
    total++; if (disp_ready !== 1'b1) $display("FAIL reset_disp_ready: got %b want 1", disp_ready); else passed++;
    total++; if (iss_op1 !== 32'd0 || iss_rd !== 5'd0) $display("FAIL reset_iss_data: got op1=%h rd=%0d want 0", iss_op1, iss_rd); else passed++;
  endtask

  task automatic test_ready_dispatch();
    iss_ready = 1'b1;
    disp(16'h0001, 5'd3, 32'd2, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0);
    total++; if (iss_valid !== 1'b0) $display("FAIL add_pre_iss: got %b want 0", iss_valid); else passed++;
    step(); idle();
    total++; if (iss_valid !== 1'b1) $display("FAIL add_iss_valid: got %b want 1", iss_valid); else passed++;
    total++; if (iss_op1 !== 32'd2 || iss_op2 !== 32'd1) $display("FAIL add_ops: got %h,%h want 2,1", iss_op1, iss_op2); else passed++;
    total++; if (iss_rd !== 5'd3 || iss_ctrl !== 16'h0001) $display("FAIL add_rd_ctrl: got %0d,%h want 3,0001", iss_rd, iss_ctrl); else passed++;
    total++; if (count !== 3'd1) $display("FAIL add_count1: got %0d want 1", count); else passed++;
    step();
    total++; if (count !== 3'd0 || iss_valid !== 1'b0) $display("FAIL add_drain: got count=%0d valid=%b want 0,0", count, iss_valid); else passed++;
  endtask

  task automatic test_wakeup();
    iss_ready = 1'b1;
    disp(16'h0002, 5'd4, 32'd6, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd5);
    step(); idle();
    total++; if (count !== 3'd1 || iss_valid !== 1'b0) $display("FAIL mul_wait: got count=%0d valid=%b want 1,0", count, iss_valid); else passed++;
    step(); step();
    total++; if (iss_valid !== 1'b0) $display("FAIL mul_still_wait: got %b want 0", iss_valid); else passed++;
    cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_data = 32'd5;
    #1;
`ifdef RS_CDB_BYPASS_EN
    total++; if (iss_valid !== 1'b1 || iss_op2 !== 32'd5 || iss_op1 !== 32'd6) $display("FAIL mul_bypass: got valid=%b op1=%h op2=%h want 1,6,5", iss_valid, iss_op1, iss_op2); else passed++;
    step(); idle();
`else
    total++; if (iss_valid !== 1'b0) $display("FAIL mul_same_cycle: got %b want 0", iss_valid); else passed++;
    step(); idle();
    total++; if (iss_valid !== 1'b1 || iss_op2 !== 32'd5 || iss_op1 !== 32'd6 || iss_rd !== 5'd4) $display("FAIL mul_issue: got valid=%b op1=%h op2=%h rd=%0d want 1,6,5,4", iss_valid, iss_op1, iss_op2, iss_rd); else passed++;
    step();
`endif
    total++; if (count !== 3'd0) $display("FAIL mul_drain: got %0d want 0", count); else passed++;
  endtask

  task automatic test_full();
    iss_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      disp(16'h0010 + 16'(k), 5'(10 + k), 32'(k), 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'(20 + k));
      step();
    end
    disp(16'h00FF, 5'd14, 32'd9, 1'b1, 5'd0, 32'd9, 1'b1, 5'd0);
    total++; if (disp_ready !== 1'b0 || count !== 3'd4) $display("FAIL full_ready: got ready=%b count=%0d want 0,4", disp_ready, count); else passed++;
    step(); idle();
    total++; if (count !== 3'd4 || iss_valid !== 1'b0) $display("FAIL full_ignored: got count=%0d valid=%b want 4,0", count, iss_valid); else passed++;
    iss_ready = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 5'd22; cdb_data = 32'h77;
    #1;
`ifdef RS_CDB_BYPASS_EN
    total++; if (iss_valid !== 1'b1 || iss_rd !== 5'd12 || iss_op2 !== 32'h77) $display("FAIL full_wake: got valid=%b rd=%0d op2=%h want 1,12,77", iss_valid, iss_rd, iss_op2); else passed++;
    step(); idle();
`else
    step(); idle();
    total++; if (iss_valid !== 1'b1 || iss_rd !== 5'd12 || iss_op2 !== 32'h77 || iss_op1 !== 32'd2) $display("FAIL full_wake: got valid=%b rd=%0d op1=%h op2=%h want 1,12,2,77", iss_valid, iss_rd, iss_op1, iss_op2); else passed++;
    total++; if (disp_ready !== 1'b0) $display("FAIL full_still_full: got %b want 0", disp_ready); else passed++;
    step();
`endif
    total++; if (count !== 3'd3 || disp_ready !== 1'b1 || iss_valid !== 1'b0) $display("FAIL full_after: got count=%0d ready=%b valid=%b want 3,1,0", count, disp_ready, iss_valid); else passed++;
    flush = 1'b1; step(); idle();
  endtask

  task automatic test_stall();
    iss_ready = 1'b0;
    disp(16'h0021, 5'd1, 32'h11, 1'b1, 5'd0, 32'h12, 1'b1, 5'd0); step();
    disp(16'h0022, 5'd2, 32'h0, 1'b0, 5'd9, 32'h22, 1'b1, 5'd0);  step();
    disp(16'h0023, 5'd3, 32'h31, 1'b1, 5'd0, 32'h32, 1'b1, 5'd0); step();
    idle();
    for (int k = 0; k < 3; k++) begin
      total++; if (iss_valid !== 1'b1 || iss_rd !== 5'd1 || iss_op1 !== 32'h11 || iss_op2 !== 32'h12) $display("FAIL stall_hold%0d: got valid=%b rd=%0d op1=%h op2=%h want 1,1,11,12", k, iss_valid, iss_rd, iss_op1, iss_op2); else passed++;
      step();
    end
    iss_ready = 1'b1;
    step();
    total++; if (iss_valid !== 1'b1 || iss_rd !== 5'd3 || iss_op1 !== 32'h31 || count !== 3'd2) $display("FAIL stall_second: got valid=%b rd=%0d op1=%h count=%0d want 1,3,31,2", iss_valid, iss_rd, iss_op1, count); else passed++;
    step();
    total++; if (iss_valid !== 1'b0 || count !== 3'd1) $display("FAIL stall_drain: got valid=%b count=%0d want 0,1", iss_valid, count); else passed++;
    flush = 1'b1; step(); idle();
  endtask

  task automatic test_same_cycle_wakeup();
    iss_ready = 1'b0;
    disp(16'h0030, 5'd6, 32'h55, 1'b0, 5'd7, 32'h2, 1'b1, 5'd0);
    cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_data = 32'hAB;
    step(); idle();
    total++; if (iss_valid !== 1'b1 || iss_op1 !== 32'hAB || iss_op2 !== 32'h2) $display("FAIL samecyc_wake: got valid=%b op1=%h op2=%h want 1,ab,2", iss_valid, iss_op1, iss_op2); else passed++;
    iss_ready = 1'b1;
    step();
    total++; if (count !== 3'd0) $display("FAIL samecyc_drain: got %0d want 0", count); else passed++;
  endtask

  task automatic test_flush();
    iss_ready = 1'b0;
    disp(16'h0041, 5'd1, 32'h1, 1'b1, 5'd0, 32'h1, 1'b1, 5'd0); step();
    disp(16'h0042, 5'd2, 32'h0, 1'b0, 5'd30, 32'h2, 1'b1, 5'd0); step();
    disp(16'h0043, 5'd3, 32'h0, 1'b0, 5'd31, 32'h3, 1'b1, 5'd0); step();
    disp(16'h0044, 5'd9, 32'h9, 1'b1, 5'd0, 32'h9, 1'b1, 5'd0);
    flush = 1'b1;
    #1;
    total++; if (iss_valid !== 1'b1 || iss_rd !== 5'd1) $display("FAIL flush_cycle_iss: got valid=%b rd=%0d want 1,1", iss_valid, iss_rd); else passed++;
    step(); idle();
    total++; if (count !== 3'd0 || iss_valid !== 1'b0 || disp_ready !== 1'b1) $display("FAIL flush_clear: got count=%0d valid=%b ready=%b want 0,0,1", count, iss_valid, disp_ready); else passed++;
    disp(16'h0041, 5'd1, 32'h1, 1'b1, 5'd0, 32'h1, 1'b1, 5'd0); step();
    disp(16'h0042, 5'd2, 32'h0, 1'b0, 5'd30, 32'h2, 1'b1, 5'd0); step();
    disp(16'h0043, 5'd3, 32'h0, 1'b0, 5'd31, 32'h3, 1'b1, 5'd0); step();
    total++; if (count !== 3'd3) $display("FAIL rst_prefill: got %0d want 3", count); else passed++;
    disp(16'h0044, 5'd9, 32'h9, 1'b1, 5'd0, 32'h9, 1'b1, 5'd0);
    rst_n = 1'b0; flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 5'd30; cdb_data = 32'h5;
    step();
    rst_n = 1'b1; idle();
    #1;
    total++; if (count !== 3'd0 || iss_valid !== 1'b0) $display("FAIL rst_clear: got count=%0d valid=%b want 0,0", count, iss_valid); else passed++;
    total++; if (iss_ctrl !== 16'd0 || iss_rd !== 5'd0 || iss_op1 !== 32'd0 || iss_op2 !== 32'd0) $display("FAIL rst_outputs: got ctrl=%h rd=%0d op1=%h op2=%h want 0", iss_ctrl, iss_rd, iss_op1, iss_op2); else passed++;
    total++; if (disp_ready !== 1'b1) $display("FAIL rst_disp_ready: got %b want 1", disp_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_full();
    test_stall();
    test_same_cycle_wakeup();
    test_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
- Small in-order-aged reservation station between instruction_decompose and the single integer ALU.
- Buffers dispatched micro-ops whose source operands are not yet valid.
- Captures missing operands from the result broadcast bus (tag and data).
- Issues the oldest fully-ready entry to the ALU through a valid/ready handshake.

Parameters:
- DEPTH, 4, number of entries (2..8).
- XLEN, 32, operand width.
- TAG_W, 5, register-tag width.
- CTRL_W, 16, opaque ALU control field carried from decode (opcode/funct).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  discard all entries (branch mispredict).
- disp_valid  in  1  decode presents a micro-op.
- disp_ready  out  1  scheduler can accept; high when count<DEPTH.
- disp_ctrl  in  CTRL_W  ALU control.
- disp_rd  in  TAG_W  destination tag.
- disp_s1, disp_s2  in  XLEN  operand values.
- disp_s1_valid, disp_s2_valid  in  1  operand already available.
- disp_rs1, disp_rs2  in  TAG_W  source tags to wait on.
- cdb_valid  in  1  result broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  XLEN  broadcast value.
- iss_valid  out  1  a ready entry is presented.
- iss_ready  in  1  ALU accepts.
- iss_ctrl  out  CTRL_W  control of the issued entry.
- iss_rd  out  TAG_W  destination tag of the issued entry.
- iss_op1, iss_op2  out  XLEN  operands of the issued entry.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset:
  - All entry valid bits clear and count=0.
  - iss_valid=0; iss_ctrl/iss_rd/iss_op1/iss_op2=0.
  - disp_ready=1 on the first cycle after reset.
- Storage: entries are kept age-ordered with the oldest at index 0, in a compacting shift queue.
- Dispatch:
  - Accepted when disp_valid&&disp_ready.
  - The new entry is written at index count, minus 1 if an issue is also taken that cycle.
  - disp_ready depends only on registered count, so there is no combinational path from iss_ready.
- Wakeup:
  - Every cycle, each valid entry compares cdb_tag with each unready source tag.
  - On a match with cdb_valid, it latches cdb_data and sets that source valid.
  - Wakeup also applies to the entry being dispatched in the same cycle, so a matching cdb beats the decode value.
- Select:
  - iss_valid is high when any entry has both sources valid.
  - The lowest such index is presented combinationally from registered entry state.
  - iss_* outputs are 0 when iss_valid=0.
- Issue: on iss_valid&&iss_ready, the selected entry is removed at the edge and younger entries shift down one index. Relative age order is preserved.
- Latency (without optional feature):
  - Dispatch with both sources valid → iss_valid on the next cycle.
  - cdb wakeup of the last missing source → iss_valid on the next cycle.
- Simultaneous dispatch+issue when full: disp_ready=0 that cycle; the dispatch is not taken.
- Stall: when iss_ready=0, the presented entry stays stable. A younger entry becoming ready does not displace an older ready one.
- Flush:
  - All entries are cleared at the edge and count=0.
  - Flush overrides dispatch, issue removal and wakeup in that cycle.
  - iss_valid is still driven combinationally during the flush cycle; the ALU must qualify it with flush.
- Duplicate tags: several entries waiting on one tag all wake on a single broadcast.
- rst_n has priority over flush.

Optional Feature:
- RS_CDB_BYPASS_EN defined:
  - Select also treats a source as ready when its tag matches the current cdb_tag with cdb_valid.
  - iss_op1/iss_op2 are muxed from cdb_data, giving 0-cycle wakeup-to-issue.
- Not defined: 1-cycle wakeup-to-issue as above, with a shorter critical path.

Decomposition:
- riscv_core_pkg holds:
  - constants XLEN, TAG_W, CTRL_W;
  - typedef rs_entry_t {valid, ctrl, rd, s1_valid, s1_tag, s1_val, s2_valid, s2_tag, s2_val};
  - function tag_match().
- Sub-module rs_entry: one slot's storage, wakeup compare and ready output. The scheduler instantiates DEPTH of them and owns the shift/select/count logic.

Test Plan:
- Dispatch add with s1=2, s2=1, both valid, iss_ready=1 → next cycle iss_valid=1, op1=2, op2=1, rd=3; then count returns to 0.
- Dispatch mul waiting on rs2=5; 3 cycles later cdb_valid, tag=5, data=5 → iss_valid rises the cycle after the broadcast with op2=5 (same cycle if RS_CDB_BYPASS_EN).
- Fill 4 entries with unready sources → disp_ready=0 and count=4. A 5th disp_valid is ignored. One broadcast wakes entry 2 → it issues, then disp_ready=1.
- Entries 0 and 2 are both ready with iss_ready=0 for 3 cycles → entry 0's outputs stay stable. On release, entry 0 issues, then entry 2 (now at index 1).
- Dispatch on rs1=7 in the same cycle as cdb tag=7, data=0xAB → entry stored ready with op1=0xAB.
- With 3 entries held, assert flush together with disp_valid → next cycle count=0 and iss_valid=0. Repeat with rst_n=0 → all outputs 0.
